// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared phase encoding and board constants for the life engines
package life_pkg;

  // Phase encoding shared with the engines' action decode
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_COPY   = 2'd2,
    ST_INIT   = 2'd3
  } life_state_t;

  localparam int BOARD_SIZE = 4096;

  // A full update sweeps every cell with a 9-cycle neighbourhood read;
  // 16 cycles per cell leaves comfortable headroom for the watchdog.
  localparam int DEFAULT_TIMEOUT = BOARD_SIZE * 16;

endpackage

// File: rtl/life_interval_timer.sv
// rtl/life_interval_timer.sv - saturating generation-interval counter with armed flag
module life_interval_timer
  import life_pkg::*;
#(
  parameter int INTERVAL = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic armed
);

  localparam int CW = $clog2(INTERVAL + 1);
  localparam logic [CW-1:0] LAST = CW'(INTERVAL);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over counting; counting stops once the interval is reached
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Armed already during the INTERVAL-th counted cycle, so a tick landing there launches
  assign armed = (count_q == LAST) || (en && (count_q == LAST - 1'b1));

endmodule

// File: rtl/life_step_scheduler.sv
// rtl/life_step_scheduler.sv - frame-aligned init/update/copy sequencer with watchdog
module life_step_scheduler
  import life_pkg::*;
#(
  parameter int CLK_HZ  = 24000000,
  parameter int STEP_HZ = 10,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int GEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic             rand_req,
  input  logic             frame_tick,
  output logic             init_start,
  output logic             upd_start,
  output logic             copy_start,
  input  logic             init_done,
  input  logic             upd_done,
  input  logic             copy_done,
  output logic             abort,
  output logic             busy,
  output logic [1:0]       phase,
  output logic [GEN_W-1:0] gen_count,
  output logic             err
);

  localparam int INTERVAL = CLK_HZ / STEP_HZ;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  // Decision is made one cycle early so abort shows exactly TIMEOUT cycles after entry
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  life_state_t      state_q, state_d;
  logic             rand_pend_q, rand_pend_d;
  logic             step_pend_q, step_pend_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic             init_start_q, init_start_d;
  logic             upd_start_q, upd_start_d;
  logic             copy_start_q, copy_start_d;
  logic             launch, first, timed_out, armed;

  life_interval_timer #(
    .INTERVAL (INTERVAL)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE && run),
    .clr   (launch),
    .armed (armed)
  );

  // Next-state, pending flags, watchdog and generation count
  always_comb begin
    state_d      = state_q;
    rand_pend_d  = rand_pend_q | rand_req;
    step_pend_d  = step_pend_q | step_req;
    gen_d        = gen_q;
    err_d        = err_q;
    abort_d      = 1'b0;
    init_start_d = 1'b0;
    upd_start_d  = 1'b0;
    copy_start_d = 1'b0;
    launch       = 1'b0;
    // The start pulse marks the first cycle of a state, where done is ignored
    first        = init_start_q | upd_start_q | copy_start_q;
    timed_out    = (wd_q == WD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          if (rand_pend_d) begin
            state_d      = ST_INIT;
            init_start_d = 1'b1;
            rand_pend_d  = 1'b0;
            step_pend_d  = 1'b0;
            launch       = 1'b1;
          end else if (step_pend_d || (run && armed)) begin
            state_d     = ST_UPDATE;
            upd_start_d = 1'b1;
            step_pend_d = 1'b0;
            launch      = 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        if (upd_done && !first) begin
          state_d      = ST_COPY;
          copy_start_d = 1'b1;
        end
      end
      ST_COPY: begin
        if (copy_done && !first) begin
          state_d = ST_IDLE;
          gen_d   = gen_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (init_done && !first) begin
          state_d = ST_IDLE;
          gen_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A done in the timeout cycle already moved the state, so it wins over the abort
    if ((state_q != ST_IDLE) && (state_d == state_q) && timed_out) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
      err_d   = 1'b1;
    end

    if (state_d != state_q) begin
      wd_d = '0;
    end else if (state_q != ST_IDLE) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; boot leaves a randomization pending
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rand_pend_q  <= 1'b1;
      step_pend_q  <= 1'b0;
      wd_q         <= '0;
      gen_q        <= '0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      init_start_q <= 1'b0;
      upd_start_q  <= 1'b0;
      copy_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rand_pend_q  <= rand_pend_d;
      step_pend_q  <= step_pend_d;
      wd_q         <= wd_d;
      gen_q        <= gen_d;
      err_q        <= err_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      init_start_q <= init_start_d;
      upd_start_q  <= upd_start_d;
      copy_start_q <= copy_start_d;
    end
  end

  assign init_start = init_start_q;
  assign upd_start  = upd_start_q;
  assign copy_start = copy_start_q;
  assign abort      = abort_q;
  assign busy       = busy_q;
  assign phase      = state_q;
  assign gen_count  = gen_q;
  assign err        = err_q;

endmodule

// File: tb/tb_life_step_scheduler.sv
// tb/tb_life_step_scheduler.sv - scoreboard bench for the generation scheduler
module tb_life_step_scheduler;
  import life_pkg::*;

  localparam int CLK_HZ   = 100;
  localparam int STEP_HZ  = 10;
  localparam int TIMEOUT  = 50;
  localparam int GEN_W    = 16;
  localparam int INTERVAL = CLK_HZ / STEP_HZ;

  localparam logic [3:0] EV_INIT  = 4'b1000;
  localparam logic [3:0] EV_UPD   = 4'b0100;
  localparam logic [3:0] EV_COPY  = 4'b0010;
  localparam logic [3:0] EV_ABORT = 4'b0001;

  logic             clk = 1'b0;
  logic             reset, run, step_req, rand_req, frame_tick;
  logic             init_done, upd_done, copy_done;
  logic             init_start, upd_start, copy_start, abort, busy, err;
  logic [1:0]       phase;
  logic [GEN_W-1:0] gen_count;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
    int         gen;
    bit         err;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  mon_ph;
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  t0;

  // Reference model: request flags, generation count, error flag and idle-run cycle count
  bit  m_rand, m_step, m_err, m_idle, noise_en;
  int  m_gen, m_cnt;

  life_step_scheduler #(
    .CLK_HZ  (CLK_HZ),
    .STEP_HZ (STEP_HZ),
    .TIMEOUT (TIMEOUT),
    .GEN_W   (GEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step_req   (step_req),
    .rand_req   (rand_req),
    .frame_tick (frame_tick),
    .init_start (init_start),
    .upd_start  (upd_start),
    .copy_start (copy_start),
    .init_done  (init_done),
    .upd_done   (upd_done),
    .copy_done  (copy_done),
    .abort      (abort),
    .busy       (busy),
    .phase      (phase),
    .gen_count  (gen_count),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push(input logic [3:0] k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.gen  = m_gen & 16'hffff;
    e.err  = (k == EV_ABORT) ? 1'b1 : m_err;
    exp_q.push_back(e);
  endtask

  // End the current cycle and start the next one with all pulses low
  task automatic next();
    if (m_idle && run && m_cnt < INTERVAL) m_cnt++;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    step_req   = 1'b0;
    rand_req   = 1'b0;
    init_done  = 1'b0;
    upd_done   = 1'b0;
    copy_done  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic set_done(input int e);
    case (e)
      0: init_done = 1'b1;
      1: upd_done  = 1'b1;
      default: copy_done = 1'b1;
    endcase
  endtask

  // Random traffic while the scheduler is busy: requests must be kept, ticks ignored
  task automatic noise();
    if (noise_en) begin
      if ($urandom_range(0, 11) == 0) begin step_req = 1'b1; m_step = 1'b1; end
      if ($urandom_range(0, 39) == 0) begin rand_req = 1'b1; m_rand = 1'b1; end
      if ($urandom_range(0, 7) == 0) frame_tick = 1'b1;
    end
  endtask

  // Called in an engine's start cycle; leaves the bench in the cycle carrying done
  task automatic wait_done(input int e, input int lat, input bit early);
    for (int k = 0; k < lat; k++) begin
      if (k == 0 && early) set_done(e);
      noise();
      next();
    end
    set_done(e);
  endtask

  // Frame tick while idle; plays the whole resulting sequence as the engines
  task automatic tick(input int la, input int lb, input bit early, input bit hang);
    frame_tick = 1'b1;
    if (m_rand) begin
      push(EV_INIT, cyc + 1);
      m_rand = 0; m_step = 0; m_cnt = 0; m_idle = 0;
      next();
      wait_done(0, la, early);
      next();
      m_gen = 0; m_idle = 1;
      chk("init_gen", gen_count, m_gen);
      chk("init_phase", phase, 0);
    end else if (m_step || (run && (m_cnt + 1 >= INTERVAL))) begin
      push(EV_UPD, cyc + 1);
      m_step = 0; m_cnt = 0; m_idle = 0;
      next();
      if (hang) begin
        push(EV_ABORT, cyc + TIMEOUT);
        for (int k = 0; k < TIMEOUT; k++) begin
          noise();
          next();
        end
        m_err = 1; m_idle = 1;
        chk("abort_err", err, 1);
        chk("abort_phase", phase, 0);
      end else begin
        wait_done(1, la, early);
        push(EV_COPY, cyc + 1);
        next();
        wait_done(2, lb, early);
        next();
        m_gen++; m_idle = 1;
        chk("gen_after_copy", gen_count, m_gen & 16'hffff);
        chk("copy_phase", phase, 0);
      end
    end else begin
      next();
      chk("no_launch_busy", busy, 0);
    end
  endtask

  // Monitor: every start/abort pulse must match the next expected event
  always @(negedge clk) begin
    if (!reset && (init_start || upd_start || copy_start || abort)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {init_start, upd_start, copy_start, abort}, 0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ph = (mon_e.kind == EV_INIT) ? 3 : (mon_e.kind == EV_UPD) ? 1 :
                 (mon_e.kind == EV_COPY) ? 2 : 0;
        chk("event_kind", {init_start, upd_start, copy_start, abort}, mon_e.kind);
        chk("event_cycle", cyc, mon_e.cyc);
        chk("event_phase", phase, mon_ph);
        chk("event_busy", busy, (mon_e.kind != EV_ABORT) ? 1 : 0);
        chk("event_gen", gen_count, mon_e.gen);
        chk("event_err", err, mon_e.err);
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; step_req = 1'b0; rand_req = 1'b0; frame_tick = 1'b0;
    init_done = 1'b0; upd_done = 1'b0; copy_done = 1'b0;
    m_rand = 1; m_step = 0; m_err = 0; m_idle = 1; m_gen = 0; m_cnt = 0; noise_en = 0;
    idle(3);
    chk("reset_phase", phase, 0);
    chk("reset_busy", busy, 0);
    chk("reset_gen", gen_count, 0);
    chk("reset_err", err, 0);
    chk("reset_starts", {init_start, upd_start, copy_start}, 0);
    chk("reset_abort", abort, 0);
    reset = 1'b0;

    // Boot: first tick randomizes the board
    idle(4);
    tick(14, 0, 0, 0);

    // Free run: one generation per tick every 30 cycles
    run = 1'b1;
    idle(12);
    repeat (3) begin
      t0 = cyc;
      tick(8, 8, 0, 0);
      while (cyc < t0 + 30) next();
    end

    // Paused single step, with a duplicate request and a done in the start cycle
    run = 1'b0;
    idle(5);
    step_req = 1'b1; m_step = 1; next();
    step_req = 1'b1; m_step = 1; next();
    idle(3);
    tick(5, 7, 1, 0);
    idle(4);
    tick(0, 0, 0, 0);
    idle(4);
    tick(0, 0, 0, 0);

    // Rand and step together with the tick: init only, step dropped
    idle(3);
    rand_req = 1'b1; step_req = 1'b1; m_rand = 1; m_step = 1;
    tick(10, 0, 0, 0);
    idle(3);
    tick(0, 0, 0, 0);

    // Step launched in the same cycle as the tick, then watchdog abort
    idle(3);
    step_req = 1'b1; m_step = 1;
    tick(6, 6, 0, 0);
    idle(3);
    step_req = 1'b1; m_step = 1; next();
    tick(0, 0, 0, 1);
    idle(3);
    // Done in the very cycle the timeout would fire takes the normal path
    step_req = 1'b1; m_step = 1; next();
    tick(TIMEOUT - 1, 3, 0, 0);
    chk("err_sticky", err, m_err);

    // Randomized traffic
    noise_en = 1;
    repeat (25) begin
      run = ($urandom_range(0, 1) == 1);
      idle($urandom_range(1, 25));
      if ($urandom_range(0, 3) == 0) begin step_req = 1'b1; m_step = 1; end
      if ($urandom_range(0, 9) == 0) begin rand_req = 1'b1; m_rand = 1; end
      tick($urandom_range(1, 20), $urandom_range(1, 20), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0));
    end
    noise_en = 0;

    // Reset during COPY
    run = 1'b0;
    idle(3);
    if (!m_rand) begin
      step_req = 1'b1; m_step = 1; next();
      frame_tick = 1'b1;
      push(EV_UPD, cyc + 1);
      m_step = 0; m_cnt = 0; m_idle = 0;
      next();
      wait_done(1, 4, 0);
      push(EV_COPY, cyc + 1);
      next();
      idle(2);
      reset = 1'b1;
      next();
      chk("midreset_phase", phase, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_gen", gen_count, 0);
      chk("midreset_err", err, 0);
      chk("midreset_starts", {init_start, upd_start, copy_start, abort}, 0);
      reset = 1'b0;
      m_rand = 1; m_step = 0; m_gen = 0; m_err = 0; m_cnt = 0; m_idle = 1;
      idle(3);
      tick(6, 0, 0, 0);
    end else begin
      tick(6, 0, 0, 0);
    end

    idle(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
